rect_filler: RTL
================

# rect_filler

Parametrised rectangle fill engine that replaces the whole-frame filler in the graphics pipeline. It accepts one rectangle command per valid/ready handshake: two corners, a 32-bit colour and a frame base address. It writes that colour into the DDR frame buffer through the address FIFO and write-data FIFO. Writes are in 8-pixel, 2-beat bursts, with pixel-granular byte masking at the left and right edges. It sits between the command processor and the DDR request FIFOs, alongside the line engine.

## Interface
- X_W, 10, x coordinate width; row pitch in address units is 2^(X_W-1)
- Y_W, 10, y coordinate width
- FRAME_W, 800, visible width in pixels (used only with clipping)
- FRAME_H, 600, visible height in pixels (used only with clipping)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  command valid
- ready  out  1  engine idle, command accepted when valid && ready
- x0, x1  in  X_W each  corner x coordinates, any order
- y0, y1  in  Y_W each  corner y coordinates, any order
- color  in  32  fill colour {8'h00, R, G, B}
- frame_base  in  32  frame base address; bits [30:0] used
- af_full  in  1  address FIFO full
- af_cmd_din  out  3  always 3'b000 (write)
- af_addr_din  out  31  burst address
- af_wr_en  out  1  address FIFO push
- wdf_full  in  1  write-data FIFO full
- wdf_din  out  128  four pixels per beat
- wdf_mask_din  out  16  byte mask, 1 = byte not written
- wdf_wr_en  out  1  write-data FIFO push

## Operation
- States: IDLE, SETUP, BEAT0, BEAT1.
- IDLE: ready=1. On valid, the engine latches all inputs and moves to SETUP. valid outside IDLE is ignored.
- SETUP (1 cycle): sort the corners to xl<=xr and yt<=yb, optionally clip, load the scan counters row=yt and blk=xl>>3, then go to BEAT0.
- BEAT0: when !af_full && !wdf_full, assert af_wr_en and wdf_wr_en together and go to BEAT1. Otherwise hold and drive no enables.
- BEAT1: when !wdf_full, assert wdf_wr_en and advance the scan. If blk < xr>>3, then blk++. Else if row < yb, then row++ and blk=xl>>3. Else go to IDLE.
- Address: af_addr_din = frame_base[30:0] + (row << (X_W-1)) + (blk << 2), modulo 2^31.
- Pixel p (0..3) of a beat occupies wdf_din[127-32p -: 32] and wdf_mask_din[15-4p -: 4]. Beat0 carries block pixels 0..3 and beat1 carries pixels 4..7.
- Pixel x = blk*8 + beat*4 + p is enabled (mask nibble 4'h0) iff xl <= x <= xr; otherwise the nibble is 4'hF. Unmasked lanes carry color.
- Bursts per command = (yb-yt+1) * ((xr>>3)-(xl>>3)+1).

## Timing
- Reset values: ready=1, af_wr_en=0, wdf_wr_en=0, af_addr_din=0, wdf_din=0, wdf_mask_din=16'hFFFF, af_cmd_din=3'b000; state IDLE.
- Handshake at edge N means ready=0 from N+1, SETUP during N+1, and the first af_wr_en no earlier than N+2.
- Unstalled throughput is one burst per 2 cycles.
- ready returns to 1 the cycle after the last BEAT1 push.
- All outputs are registered. Enables are combinationally qualified by the current full flags only within the state decode; no push happens while the relevant full flag is high.
- Reset mid-operation aborts immediately: enables drop asynchronously and the state becomes IDLE. A burst may be left with only beat0 pushed; the DDR controller owns recovery.
- Counters are X_W/Y_W wide. Unclipped coordinates at the max value must not wrap the scan: the termination compare uses equality before the increment.

## Configuration
- RECT_FILLER_CLIP_EN defined:
  - SETUP clamps xr to FRAME_W-1 and yb to FRAME_H-1.
  - If xl > FRAME_W-1 or yt > FRAME_H-1, no bursts are issued and the engine returns to IDLE right after SETUP (ready=1 at N+2).
- RECT_FILLER_CLIP_EN undefined: coordinates are used unmodified. FRAME_W and FRAME_H are unused.

## Structure
- Package rect_filler_pkg holds:
  - the state enum;
  - AF_CMD_WRITE = 3'b000;
  - PIX_PER_BEAT = 4, BEATS_PER_BURST = 2;
  - MASK_NONE = 16'hFFFF.
- One sub-module, rect_filler_scan, contains the row/blk counters, the advance/done logic and the address computation. The top level keeps the FSM, mask generation and FIFO interface.

## Test plan
- Single pixel: (x0,y0)=(13,5)=(x1,y1), base 32'h10400000, colour 32'h007F0000.
  - Expect exactly one burst at addr 31'h10400A04.
  - Beat0 mask 16'hFFFF; beat1 mask 16'hF0FF.
  - ready=1 four cycles after the handshake, with no stalls.
- Swapped corners: (x0,y0)=(17,3), (x1,y1)=(2,1).
  - Expect 3 rows x 3 blocks = 9 bursts.
  - First burst beat0 mask 16'hFF00; last burst beat1 mask 16'hFFFF.
- Backpressure: rectangle (0,0)-(15,0).
  - Hold af_full high for 5 cycles, then toggle wdf_full every other cycle.
  - Expect exactly 2 af pushes and 4 wdf pushes, no push while the relevant full flag is high, and unchanged data ordering.
- Full frame with RECT_FILLER_CLIP_EN: (0,0)-(1023,1023).
  - Expect 60000 bursts, all masks 16'h0000.
  - Last address is base + (599<<9) + (99<<2).
- Off-screen with RECT_FILLER_CLIP_EN: (900,0)-(950,10).
  - Expect zero pushes and ready=1 two cycles after the handshake.
- Reset mid-fill: assert rst_n=0 during the 10th burst.
  - Enables are low asynchronously and ready=1 after release.
  - A new command then fills correctly.

Source files
------------

// File: rtl/rect_filler_pkg.sv
// Shared types and constants for the rectangle fill engine.
package rect_filler_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, BEAT0, BEAT1} state_t;

  localparam logic [2:0]  AF_CMD_WRITE    = 3'b000;
  localparam int          PIX_PER_BEAT    = 4;
  localparam int          BEATS_PER_BURST = 2;
  localparam logic [15:0] MASK_NONE       = 16'hFFFF;
endpackage

// File: rtl/rect_filler_scan.sv
// Row/block scan counters for rect_filler and the registered DDR burst address.
module rect_filler_scan
  import rect_filler_pkg::*;
#(
  parameter int X_W = 10,
  parameter int Y_W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           advance,
  input  logic [X_W-1:0] xl,
  input  logic [X_W-1:0] xr,
  input  logic [Y_W-1:0] yt,
  input  logic [Y_W-1:0] yb,
  input  logic [30:0]    base,
  output logic [X_W-4:0] blk_next,
  output logic           done,
  output logic [30:0]    addr
);
  logic [X_W-4:0] blk, blk_first, blk_last;
  logic [Y_W-1:0] row, row_next;

  assign blk_first = xl[X_W-1:3];
  assign blk_last  = xr[X_W-1:3];
  // Equality compares keep coordinates at the counter maximum from wrapping.
  assign done      = (blk == blk_last) && (row == yb);

  always_comb begin
    row_next = row;
    blk_next = blk;
    if (load) begin
      row_next = yt;
      blk_next = blk_first;
    end else if (advance) begin
      if (blk != blk_last) begin
        blk_next = blk + 1'b1;
      end else if (row != yb) begin
        row_next = row + 1'b1;
        blk_next = blk_first;
      end
    end
  end

  // Address tracks the next counter values so it is valid in the beat it is pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      blk  <= '0;
      addr <= '0;
    end else begin
      row  <= row_next;
      blk  <= blk_next;
      addr <= base + (31'(row_next) << (X_W-1)) + (31'(blk_next) << $clog2(PIX_PER_BEAT));
    end
  end
endmodule

// File: rtl/rect_filler.sv
// Rectangle fill engine: FSM, edge masking and DDR FIFO interface.
// Optional frame clipping is enabled by defining RECT_FILLER_CLIP_EN.
module rect_filler
  import rect_filler_pkg::*;
#(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int FRAME_W = 800,
  parameter int FRAME_H = 600
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           valid,
  output logic           ready,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  input  logic [31:0]    color,
  input  logic [31:0]    frame_base,
  input  logic           af_full,
  output logic [2:0]     af_cmd_din,
  output logic [30:0]    af_addr_din,
  output logic           af_wr_en,
  input  logic           wdf_full,
  output logic [127:0]   wdf_din,
  output logic [15:0]    wdf_mask_din,
  output logic           wdf_wr_en
);
`ifdef RECT_FILLER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif
  localparam logic [X_W-1:0] X_MAX = X_W'(FRAME_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(FRAME_H - 1);

  state_t         state, state_next;
  logic [X_W-1:0] x0_q, x1_q, xl, xr, xr_s;
  logic [Y_W-1:0] y0_q, y1_q, yt, yb, yb_s;
  logic [31:0]    color_q;
  logic [30:0]    base_q;
  logic           off_screen, load, advance, done;
  logic [X_W-4:0] blk_next;
  logic [15:0]    mask_next;
  logic [127:0]   din_next;
  logic           unused_base_msb;

  assign unused_base_msb = frame_base[31];
  assign af_cmd_din      = AF_CMD_WRITE;

  function automatic logic [15:0] lane_mask(input logic [X_W-4:0] b, input logic beat,
                                            input logic [X_W-1:0] lo, input logic [X_W-1:0] hi);
    logic [X_W-1:0] x;
    lane_mask = MASK_NONE;
    for (int p = 0; p < PIX_PER_BEAT; p++) begin
      x = {b, beat, 2'(p)};
      if (x >= lo && x <= hi) lane_mask[15-4*p -: 4] = 4'h0;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (state == IDLE && valid) begin
      x0_q    <= x0;
      x1_q    <= x1;
      y0_q    <= y0;
      y1_q    <= y1;
      color_q <= color;
      base_q  <= frame_base[30:0];
    end
  end

  // Corner sort and optional clamp; latched corners are stable for the whole command.
  always_comb begin
    xl         = (x0_q <= x1_q) ? x0_q : x1_q;
    xr_s       = (x0_q <= x1_q) ? x1_q : x0_q;
    yt         = (y0_q <= y1_q) ? y0_q : y1_q;
    yb_s       = (y0_q <= y1_q) ? y1_q : y0_q;
    xr         = xr_s;
    yb         = yb_s;
    off_screen = 1'b0;
    if (CLIP) begin
      if (xr_s > X_MAX) xr = X_MAX;
      if (yb_s > Y_MAX) yb = Y_MAX;
      off_screen = (xl > X_MAX) || (yt > Y_MAX);
    end
  end

  rect_filler_scan #(.X_W(X_W), .Y_W(Y_W)) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .advance  (advance),
    .xl       (xl),
    .xr       (xr),
    .yt       (yt),
    .yb       (yb),
    .base     (base_q),
    .blk_next (blk_next),
    .done     (done),
    .addr     (af_addr_din)
  );

  always_comb begin
    state_next = state;
    af_wr_en   = 1'b0;
    wdf_wr_en  = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE:  if (valid) state_next = SETUP;
      SETUP: begin
        load       = 1'b1;
        state_next = off_screen ? IDLE : BEAT0;
      end
      BEAT0: if (!af_full && !wdf_full) begin
        af_wr_en   = 1'b1;
        wdf_wr_en  = 1'b1;
        state_next = BEAT1;
      end
      BEAT1: if (!wdf_full) begin
        wdf_wr_en  = 1'b1;
        advance    = 1'b1;
        state_next = done ? IDLE : BEAT0;
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat data is prepared one cycle ahead, keyed to the state being entered.
  always_comb begin
    mask_next = MASK_NONE;
    din_next  = '0;
    if (state_next == BEAT0 || state_next == BEAT1) begin
      mask_next = lane_mask(blk_next, state_next == BEAT1, xl, xr);
      for (int p = 0; p < PIX_PER_BEAT; p++)
        if (mask_next[15-4*p -: 4] == 4'h0) din_next[127-32*p -: 32] = color_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ready        <= 1'b1;
      wdf_din      <= '0;
      wdf_mask_din <= MASK_NONE;
    end else begin
      state        <= state_next;
      ready        <= (state_next == IDLE);
      wdf_din      <= din_next;
      wdf_mask_din <= mask_next;
    end
  end
endmodule
